// File: rtl/attn_buf_pkg.sv
// Shared constants and types for the attention output buffer.
// Holds the output RAM geometry (word width, depth, address width) and
// the circular-buffer pointer type, which carries one extra wrap bit above
// the RAM address so that full and empty can be told apart.
package attn_buf_pkg;

    localparam int DATA_WIDTH     = 16;
    localparam int OUT_RAM_DEPTH  = 512;
    localparam int OUT_RAM_AWIDTH = 9;

    // Pointer into the output RAM: [OUT_RAM_AWIDTH] is the wrap bit,
    // [OUT_RAM_AWIDTH-1:0] is the RAM address.
    typedef logic [OUT_RAM_AWIDTH:0] out_ram_ptr_t;

endpackage

// File: rtl/out_ram_fifo_ctrl_if.sv
// Stream interface between the FIFO controller and its producer/consumer.
//   in_valid/in_data/in_ready    : producer -> controller handshake
//   out_valid/out_data/out_ready : controller -> consumer handshake
// The slave modport is the controller's view; master is the environment's.
interface out_ram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = attn_buf_pkg::DATA_WIDTH
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/out_skid_queue.sv
// Two-entry registered FIFO that absorbs the RAM's registered read data.
// Ports:
//   clk, resetn   : clock, async active-low reset
//   clr           : synchronous clear (wins over push/pop)
//   push/push_data: write one word
//   pop           : drop the head word (caller guarantees count != 0)
//   count         : occupancy 0..2
//   head          : oldest word; zero after reset
// The caller guarantees a push never arrives while full without a pop.
module out_skid_queue #(
    parameter int DATA_WIDTH = attn_buf_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clr,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] head
);
    logic [DATA_WIDTH-1:0] slot [2];
    logic                  wr_sel;
    logic                  rd_sel;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_sel  <= 1'b0;
            rd_sel  <= 1'b0;
            count   <= 2'd0;
        end else if (clr) begin
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                slot[wr_sel] <= push_data;
                wr_sel       <= !wr_sel;
            end
            if (pop) begin
                rd_sel <= !rd_sel;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = slot[rd_sel];

endmodule

// File: rtl/out_ram_fifo_ctrl.sv
// Circular-buffer controller around the 512 x 16 dual-port output RAM.
// Port A writes accepted producer words; port B reads them back in order.
// The one-cycle registered RAM read is hidden by a 2-entry skid queue so
// both sides can move one word per cycle.
// Ports:
//   clk, resetn  : clock, async active-low reset
//   flush        : synchronous clear of pointers, inflight flag and queue
//   stream       : producer/consumer valid/ready handshakes (slave side)
//   fill_level   : words committed to RAM and not yet issued for read
//   address_a, wren_a, data_a : RAM write port
//   address_b, wren_b         : RAM read port (wren_b tied low)
//   out_b        : RAM port-B registered read data
module out_ram_fifo_ctrl
    import attn_buf_pkg::*;
#(
    parameter int DATA_WIDTH = attn_buf_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = OUT_RAM_AWIDTH,
    parameter int DEPTH      = OUT_RAM_DEPTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    out_ram_fifo_ctrl_if.slave    stream,
    output logic [ADDR_WIDTH:0]   fill_level,
    output logic [ADDR_WIDTH-1:0] address_a,
    output logic                  wren_a,
    output logic [DATA_WIDTH-1:0] data_a,
    output logic [ADDR_WIDTH-1:0] address_b,
    output logic                  wren_b,
    input  logic [DATA_WIDTH-1:0] out_b
);
    localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] PTR_ONE    = (ADDR_WIDTH + 1)'(1);

    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic                inflight;
    logic [1:0]          q_count;
    logic                accept;
    logic                pop;
    logic                issue;
    logic [2:0]          q_claim;

    // Wrap-bit arithmetic makes the difference exact over 0..DEPTH.
    assign fill_level = wr_ptr - rd_ptr;

    // Write side: depends only on registered wr_ptr/rd_ptr and inputs, so
    // there is no path from out_ready to in_ready.
    assign stream.in_ready = !flush && (fill_level != FULL_LEVEL);
    assign accept          = stream.in_valid && stream.in_ready;
    assign wren_a          = accept;
    assign address_a       = wr_ptr[ADDR_WIDTH-1:0];
    assign data_a          = stream.in_data;

    assign address_b = rd_ptr[ADDR_WIDTH-1:0];
    assign wren_b    = 1'b0;

    assign stream.out_valid = (q_count != 2'd0);
    assign pop              = stream.out_valid && stream.out_ready;

    // Queue slots already spoken for once this cycle's pop is taken into
    // account; an issue is only launched if its data is sure to find a slot
    // when it lands next cycle.
    assign q_claim = {1'b0, q_count} + {2'b0, inflight} - {2'b0, pop};
    assign issue   = !flush && (fill_level != '0) && (q_claim < 3'd2);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            inflight <= issue;
        end
    end

    // out_b carries the issued word in the cycle after the issue edge.
    out_skid_queue #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .resetn    (resetn),
        .clr       (flush),
        .push      (inflight),
        .push_data (out_b),
        .pop       (pop),
        .count     (q_count),
        .head      (stream.out_data)
    );

endmodule

// File: tb/tb_out_ram_fifo_ctrl.sv
// Bench for out_ram_fifo_ctrl: behavioural dual-port RAM, a scoreboard queue
// of accepted words checked in order at the consumer, and directed phases
// for latency, full, wrap, throughput, reset and flush behaviour.
module tb_out_ram_fifo_ctrl;
    localparam int DW    = 16;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic          clk = 1'b0;
    logic          resetn;
    logic          flush;
    logic [AW:0]   fill_level;
    logic [AW-1:0] address_a;
    logic          wren_a;
    logic [DW-1:0] data_a;
    logic [AW-1:0] address_b;
    logic          wren_b;
    logic [DW-1:0] out_b;

    out_ram_fifo_ctrl_if #(.DATA_WIDTH(DW)) sif ();

    out_ram_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .stream     (sif),
        .fill_level (fill_level),
        .address_a  (address_a),
        .wren_a     (wren_a),
        .data_a     (data_a),
        .address_b  (address_b),
        .wren_b     (wren_b),
        .out_b      (out_b)
    );

    always #5 clk = ~clk;

    // Registered-output dual-port RAM.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (wren_a) ram[address_a] <= data_a;
        out_b <= ram[address_b];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: every accepted word, oldest first. The block must
    // hand them out in exactly this order, and at most two words may live
    // outside the RAM at any time.
    logic [DW-1:0] exp_q [$];
    int wr_cnt  = 0;
    int pop_cnt = 0;
    int stall   = 0;
    int held;

    always @(negedge clk) begin
        if (!resetn) begin
            exp_q.delete();
            wr_cnt  = 0;
            pop_cnt = 0;
            stall   = 0;
        end else if (flush) begin
            check("flush_in_ready", 32'(sif.in_ready), 32'd0);
            check("flush_wren_a", 32'(wren_a), 32'd0);
            exp_q.delete();
            wr_cnt  = 0;
            pop_cnt = 0;
            stall   = 0;
        end else begin
            held = (32'(address_b) - pop_cnt) & (DEPTH - 1);
            check("held_le_2", 32'(held <= 2), 32'd1);
            check("fill_vs_model", 32'(fill_level) + 32'(held), 32'(exp_q.size()));
            if (exp_q.size() <= DEPTH - 1) check("in_ready_room", 32'(sif.in_ready), 32'd1);
            if (exp_q.size() == DEPTH + 2) check("in_ready_full", 32'(sif.in_ready), 32'd0);
            if (exp_q.size() == 0) check("out_valid_empty", 32'(sif.out_valid), 32'd0);
            if (sif.out_valid && exp_q.size() != 0)
                check("out_data", 32'(sif.out_data), 32'(exp_q[0]));
            stall = (exp_q.size() != 0 && !sif.out_valid) ? stall + 1 : 0;
            check("stall_le_2", 32'(stall <= 2), 32'd1);
            if (sif.in_valid && sif.in_ready) begin
                check("wren_a_accept", 32'(wren_a), 32'd1);
                check("address_a", 32'(address_a), 32'(wr_cnt % DEPTH));
                check("data_a", 32'(data_a), 32'(sif.in_data));
                exp_q.push_back(sif.in_data);
                wr_cnt++;
            end else begin
                check("wren_a_idle", 32'(wren_a), 32'd0);
            end
            check("wren_b", 32'(wren_b), 32'd0);
            if (sif.out_valid && sif.out_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                pop_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge.
    task automatic drain(input string name);
        sif.in_valid  = 1'b0;
        sif.out_ready = 1'b1;
        for (int n = 0; n < 3000 && exp_q.size() != 0; n++) step();
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int sent;
        int accepts;
        int pops;
        int bubbles;
        bit seen;
        bit got;

        resetn        = 1'b0;
        flush         = 1'b0;
        sif.in_valid  = 1'b0;
        sif.in_data   = 16'hA5A5;
        sif.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(sif.out_valid), 32'd0);
        check("rst_out_data", 32'(sif.out_data), 32'd0);
        check("rst_fill", 32'(fill_level), 32'd0);
        check("rst_in_ready", 32'(sif.in_ready), 32'd1);
        check("rst_wren_a", 32'(wren_a), 32'd0);
        check("rst_address_a", 32'(address_a), 32'd0);
        check("rst_address_b", 32'(address_b), 32'd0);
        check("rst_data_a", 32'(data_a), 32'hA5A5);

        // Single word: accepted at edge k, visible after edge k+2.
        step();
        sif.in_valid  = 1'b1;
        sif.in_data   = 16'h3C00;
        sif.out_ready = 1'b1;
        step();
        sif.in_valid = 1'b0;
        @(negedge clk);
        check("lat_k_valid", 32'(sif.out_valid), 32'd0);
        step();
        @(negedge clk);
        check("lat_k1_valid", 32'(sif.out_valid), 32'd0);
        check("lat_k1_fill", 32'(fill_level), 32'd0);
        step();
        @(negedge clk);
        check("lat_k2_valid", 32'(sif.out_valid), 32'd1);
        check("lat_k2_data", 32'(sif.out_data), 32'h3C00);
        check("lat_k2_fill", 32'(fill_level), 32'd0);
        step();
        @(negedge clk);
        check("single_popped", 32'(sif.out_valid), 32'd0);

        // Reset in the middle of a buffered stream.
        step();
        sif.out_ready = 1'b0;
        sif.in_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sif.in_data = 16'(32'h0100 + i);
            step();
        end
        sif.in_valid = 1'b0;
        @(negedge clk);
        check("mid_pre_valid", 32'(sif.out_valid), 32'd1);
        @(posedge clk);
        #1 resetn = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(sif.out_valid), 32'd0);
        check("mid_rst_fill", 32'(fill_level), 32'd0);
        check("mid_rst_in_ready", 32'(sif.in_ready), 32'd1);
        check("mid_rst_wren_a", 32'(wren_a), 32'd0);
        step();
        step();
        resetn = 1'b1;
        @(negedge clk);
        check("post_rst_valid", 32'(sif.out_valid), 32'd0);
        check("post_rst_fill", 32'(fill_level), 32'd0);
        check("post_rst_in_ready", 32'(sif.in_ready), 32'd1);

        // Fill to full with the consumer stalled.
        step();
        sif.out_ready = 1'b0;
        sif.in_valid  = 1'b1;
        for (int i = 0; i < 512; i++) begin
            sif.in_data = 16'(32'h8000 + i);
            step();
        end
        sif.in_valid = 1'b0;
        @(negedge clk);
        check("full510_fill", 32'(fill_level), 32'd510);
        check("full510_in_ready", 32'(sif.in_ready), 32'd1);
        check("full510_valid", 32'(sif.out_valid), 32'd1);
        check("full510_head", 32'(sif.out_data), 32'h8000);
        step();
        sif.in_valid = 1'b1;
        sif.in_data  = 16'h8200;
        step();
        sif.in_data  = 16'h8201;
        step();
        sif.in_data  = 16'hDEAD;
        @(negedge clk);
        check("full512_fill", 32'(fill_level), 32'd512);
        check("full512_in_ready", 32'(sif.in_ready), 32'd0);
        step();
        step();
        @(negedge clk);
        check("full_hold_fill", 32'(fill_level), 32'd512);
        check("full_hold_in_ready", 32'(sif.in_ready), 32'd0);
        step();
        drain("full_drain");

        // Random traffic across several address wraps.
        sent = 0;
        for (int c = 0; c < 20000 && sent < 1500; c++) begin
            sif.in_valid  = ($urandom_range(0, 3) != 0);
            sif.in_data   = 16'(sent);
            sif.out_ready = ($urandom_range(0, 1) != 0);
            @(negedge clk);
            if (sif.in_valid && sif.in_ready) sent++;
            step();
        end
        check("wrap_sent", 32'(sent), 32'd1500);
        drain("wrap_drain");

        // Continuous traffic: the first word appears three samples after it
        // is first presented, then one word every cycle.
        accepts = 0;
        pops    = 0;
        bubbles = 0;
        seen    = 1'b0;
        sif.in_valid  = 1'b1;
        sif.out_ready = 1'b1;
        for (int c = 0; c < 600; c++) begin
            sif.in_data = 16'(32'h4000 + c);
            @(negedge clk);
            if (sif.in_valid && sif.in_ready) accepts++;
            if (sif.out_valid) begin
                pops++;
                seen = 1'b1;
            end else if (seen) begin
                bubbles++;
            end
            step();
        end
        check("tput_accepts", 32'(accepts), 32'd600);
        check("tput_pops", 32'(pops), 32'd597);
        check("tput_bubbles", 32'(bubbles), 32'd0);
        drain("tput_drain");

        // Flush with 300 words buffered; a new word must be first out.
        sif.out_ready = 1'b0;
        sif.in_valid  = 1'b1;
        for (int i = 0; i < 300; i++) begin
            sif.in_data = 16'(32'h6000 + i);
            step();
        end
        flush       = 1'b1;
        sif.in_data = 16'hBEEF;
        @(negedge clk);
        check("pre_flush_fill", 32'(fill_level), 32'd298);
        step();
        flush        = 1'b0;
        sif.in_valid = 1'b0;
        @(negedge clk);
        check("flush_fill", 32'(fill_level), 32'd0);
        check("flush_valid", 32'(sif.out_valid), 32'd0);
        check("flush_address_b", 32'(address_b), 32'd0);
        step();
        sif.in_valid  = 1'b1;
        sif.in_data   = 16'h1234;
        sif.out_ready = 1'b1;
        step();
        sif.in_valid = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (sif.out_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("flush_first_valid", 32'(got), 32'd1);
        check("flush_first_word", 32'(sif.out_data), 32'h1234);
        step();
        drain("flush_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
